// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 calculator keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   localparam logic [3:0] KEY_A    = 4'd10;
   localparam logic [3:0] KEY_B    = 4'd11;
   localparam logic [3:0] KEY_C    = 4'd12;
   localparam logic [3:0] KEY_D    = 4'd13;
   localparam logic [3:0] KEY_STAR = 4'd14;
   localparam logic [3:0] KEY_HASH = 4'd15;

   // Physical (row, column) position to calculator key code; digits are BCD.
   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'h0: code = 4'd1;
         4'h1: code = 4'd2;
         4'h2: code = 4'd3;
         4'h3: code = KEY_A;
         4'h4: code = 4'd4;
         4'h5: code = 4'd5;
         4'h6: code = 4'd6;
         4'h7: code = KEY_B;
         4'h8: code = 4'd7;
         4'h9: code = 4'd8;
         4'hA: code = 4'd9;
         4'hB: code = KEY_C;
         4'hC: code = KEY_STAR;
         4'hD: code = 4'd0;
         4'hE: code = KEY_HASH;
         default: code = KEY_D;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_debounce_cnt.sv
// Saturating match counter shared by press confirmation and release detection.
module keypad_debounce_cnt #(
   parameter int unsigned TARGET = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_done
);

   localparam int unsigned CW = (TARGET < 1) ? 1 : $clog2(TARGET + 1);

   logic [CW-1:0] r_cnt;

   // Clear wins over increment; the count holds once it reaches TARGET.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != CW'(TARGET))) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // High when the next increment brings the count to TARGET.
   assign o_done = (r_cnt >= CW'(TARGET - 1));

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column scanner, row sampler and single-key debouncer for the 4x4 keypad.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DEBOUNCE_CNT = 8,
   parameter int unsigned CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_i,
   output logic [1:0] col_sel_o,
   output logic [3:0] key_code_o,
   output logic       key_valid_o,
   output logic       key_held_o
);

   logic [3:0]       r_row_m;
   logic [3:0]       r_row_s;
   logic [CNT_W-1:0] r_dwell;
   state_t           r_state;
   logic [1:0]       r_row_lat;
   logic [1:0]       r_col;
   logic [3:0]       r_code;
   logic             r_valid;
   logic             r_held;

   logic             w_sample;
   logic             w_any;
   logic [1:0]       w_row_idx;
   logic             w_row_hit;
   logic             w_cnt_clr;
   logic             w_cnt_inc;
   logic             w_cnt_done;
   state_t           w_state_nxt;
   logic [1:0]       w_lat_nxt;
   logic [1:0]       w_col_nxt;
   logic [3:0]       w_code_nxt;
   logic             w_valid_nxt;
   logic             w_held_nxt;

   // Two-flop synchroniser for the asynchronous row lines.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row_m <= '0;
         r_row_s <= '0;
      end else begin
         r_row_m <= row_i;
         r_row_s <= r_row_m;
      end
   end

   // Free-running dwell counter; its terminal count is the sample event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dwell <= '0;
      end else if (r_dwell == CNT_W'(SCAN_DIV - 1)) begin
         r_dwell <= '0;
      end else begin
         r_dwell <= r_dwell + 1'b1;
      end
   end

   assign w_sample  = (r_dwell == CNT_W'(SCAN_DIV - 1));
   assign w_any     = (r_row_s != 4'b0000);
   assign w_row_hit = r_row_s[r_row_lat];

   // Row priority: lowest set bit wins.
   always_comb begin
      w_row_idx = 2'd0;
      if (r_row_s[0])      w_row_idx = 2'd0;
      else if (r_row_s[1]) w_row_idx = 2'd1;
      else if (r_row_s[2]) w_row_idx = 2'd2;
      else if (r_row_s[3]) w_row_idx = 2'd3;
   end

   keypad_debounce_cnt #(
      .TARGET (DEBOUNCE_CNT)
   ) u_match_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_cnt_clr),
      .i_inc  (w_cnt_inc),
      .o_done (w_cnt_done)
   );

   // FSM next-state and output decisions, taken only on sample events.
   // One counter serves both press confirmation and release detection; it is
   // held clear while scanning so a single-sample debounce accepts from SCAN.
   always_comb begin
      w_state_nxt = r_state;
      w_lat_nxt   = r_row_lat;
      w_col_nxt   = r_col;
      w_code_nxt  = r_code;
      w_valid_nxt = 1'b0;
      w_held_nxt  = r_held;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      unique case (r_state)
         SCAN: begin
            w_cnt_clr = 1'b1;
            if (w_sample) begin
               if (w_any) begin
                  w_lat_nxt = w_row_idx;
                  if (w_cnt_done) begin
                     w_code_nxt  = key_map(w_row_idx, r_col);
                     w_valid_nxt = 1'b1;
                     w_held_nxt  = 1'b1;
                     w_state_nxt = HELD;
                  end else begin
                     w_cnt_clr   = 1'b0;
                     w_cnt_inc   = 1'b1;
                     w_state_nxt = DEBOUNCE;
                  end
               end else begin
                  w_col_nxt = r_col + 2'd1;
               end
            end
         end
         DEBOUNCE: begin
            if (w_sample) begin
               if (w_any && (w_row_idx == r_row_lat)) begin
                  if (w_cnt_done) begin
                     w_code_nxt  = key_map(r_row_lat, r_col);
                     w_valid_nxt = 1'b1;
                     w_held_nxt  = 1'b1;
                     w_state_nxt = HELD;
                     w_cnt_clr   = 1'b1;
                  end else begin
                     w_cnt_inc = 1'b1;
                  end
               end else begin
                  w_cnt_clr   = 1'b1;
                  w_col_nxt   = r_col + 2'd1;
                  w_state_nxt = SCAN;
               end
            end
         end
         HELD: begin
            if (w_sample) begin
               if (!w_row_hit) begin
                  if (w_cnt_done) begin
                     w_held_nxt  = 1'b0;
                     w_col_nxt   = r_col + 2'd1;
                     w_state_nxt = SCAN;
                     w_cnt_clr   = 1'b1;
                  end else begin
                     w_cnt_inc = 1'b1;
                  end
               end else begin
                  w_cnt_clr = 1'b1;
               end
            end
         end
         default: begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = SCAN;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= SCAN;
         r_row_lat <= '0;
         r_col     <= '0;
         r_code    <= '0;
         r_valid   <= 1'b0;
         r_held    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_row_lat <= w_lat_nxt;
         r_col     <= w_col_nxt;
         r_code    <= w_code_nxt;
         r_valid   <= w_valid_nxt;
         r_held    <= w_held_nxt;
      end
   end

   assign col_sel_o   = r_col;
   assign key_code_o  = r_code;
   assign key_valid_o = r_valid;
   assign key_held_o  = r_held;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: an emulated key matrix drives the rows,
// a sample-level reference model predicts outputs, a monitor compares.
module tb_keypad_scan_ctrl;

   localparam int SD = 4;
   localparam int DC = 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] row_i = 4'b0000;
   logic [1:0] col_sel_o;
   logic [3:0] key_code_o;
   logic       key_valid_o;
   logic       key_held_o;

   always #5 clk = ~clk;

   keypad_scan_ctrl #(
      .SCAN_DIV     (SD),
      .DEBOUNCE_CNT (DC),
      .CNT_W        (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .row_i       (row_i),
      .col_sel_o   (col_sel_o),
      .key_code_o  (key_code_o),
      .key_valid_o (key_valid_o),
      .key_held_o  (key_held_o)
   );

   int n_cmp   = 0;
   int n_bad   = 0;
   int n_valid = 0;

   // Keys currently pressed, bit index = row*4 + col.
   logic [15:0] keys_down = 16'h0000;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Key matrix emulation: a pressed key connects its row to the selected column.
   always @(negedge clk) begin
      logic [3:0] r;
      r = 4'b0000;
      for (int k = 0; k < 16; k++)
         if (keys_down[k] && (col_sel_o == 2'(k % 4))) r[k / 4] = 1'b1;
      row_i = r;
   end

   // ---------------- reference model ----------------
   int KEYMAP[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
   int m_cycle;                   // cycles since reset, sample when mod SD == SD-1
   int m_col, m_code, m_held, m_valid;
   int m_mode;                    // 0 looking, 1 confirming press, 2 key held
   int m_cnt, m_lat;
   logic [3:0] m_seen1, m_seen2;  // rows as they emerge through the two sync stages
   int exp_q[$];

   function void model_accept();
      m_code  = KEYMAP[m_lat * 4 + m_col];
      m_valid = 1;
      m_held  = 1;
      m_mode  = 2;
      m_cnt   = 0;
      exp_q.push_back(m_code);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int low;
      if (!rst_n) begin
         m_cycle = 0; m_col = 0; m_code = 0; m_held = 0; m_valid = 0;
         m_mode = 0; m_cnt = 0; m_lat = 0;
         m_seen1 = 4'b0000; m_seen2 = 4'b0000;
         exp_q.delete();
      end else begin
         m_valid = 0;
         if (m_cycle % SD == SD - 1) begin
            low = -1;
            for (int i = 3; i >= 0; i--) if (m_seen2[i]) low = i;
            case (m_mode)
               0: if (low < 0) m_col = (m_col + 1) % 4;
                  else begin
                     m_lat = low; m_cnt = 1;
                     if (m_cnt == DC) model_accept(); else m_mode = 1;
                  end
               1: if (low == m_lat) begin
                     m_cnt++;
                     if (m_cnt == DC) model_accept();
                  end else begin
                     m_mode = 0; m_col = (m_col + 1) % 4;
                  end
               default: if (!m_seen2[m_lat]) begin
                     m_cnt++;
                     if (m_cnt == DC) begin
                        m_held = 0; m_mode = 0; m_cnt = 0; m_col = (m_col + 1) % 4;
                     end
                  end else m_cnt = 0;
            endcase
         end
         m_seen2 = m_seen1;
         m_seen1 = row_i;
         m_cycle++;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         check("col_sel", int'(col_sel_o), m_col);
         check("key_held", int'(key_held_o), m_held);
         check("key_valid", int'(key_valid_o), m_valid);
         check("key_code_reg", int'(key_code_o), m_code);
         if (key_valid_o) begin
            n_valid++;
            if (exp_q.size() == 0) check("spurious_valid", int'(key_valid_o), 0);
            else check("key_code_pop", int'(key_code_o), exp_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_held(input logic lvl, input int max_cyc);
      for (int i = 0; i < max_cyc && key_held_o !== lvl; i++) @(negedge clk);
      check("wait_held", int'(key_held_o), int'(lvl));
   endtask

   task automatic wait_col(input int c, input int max_cyc);
      for (int i = 0; i < max_cyc && int'(col_sel_o) != c; i++) @(negedge clk);
      check("wait_col", int'(col_sel_o), c);
   endtask

   initial begin
      int v0;
      // reset state
      #12;
      check("rst_col", int'(col_sel_o), 0);
      check("rst_code", int'(key_code_o), 0);
      check("rst_valid", int'(key_valid_o), 0);
      check("rst_held", int'(key_held_o), 0);
      @(negedge clk); rst_n = 1'b1;

      // idle scanning
      repeat (40) @(negedge clk);
      check("idle_no_valid", n_valid, 0);

      // key 6 (row1, col2)
      keys_down = 16'h0040;
      wait_held(1'b1, 100);
      check("key6_code", int'(key_code_o), 6);
      check("key6_col_frozen", int'(col_sel_o), 2);
      repeat (10) @(negedge clk);
      keys_down = 16'h0000;
      wait_held(1'b0, 100);
      @(negedge clk);
      check("resume_col3", int'(col_sel_o), 3);

      // bounce on column 1: key 2 (row0, col1) touched briefly
      v0 = n_valid;
      wait_col(1, 40);
      keys_down = 16'h0002;
      repeat (SD) @(negedge clk);
      keys_down = 16'h0000;
      repeat (30) @(negedge clk);
      check("bounce_no_valid", n_valid - v0, 0);

      // keys 1 and * together on column 0: row 0 wins
      wait_col(3, 40);
      keys_down = 16'h1001;
      wait_held(1'b1, 100);
      check("prio_code", int'(key_code_o), 1);
      keys_down = 16'h0000;
      wait_held(1'b0, 100);

      // key 0 (row3, col1) held, reset mid-HELD
      keys_down = 16'h2000;
      wait_held(1'b1, 100);
      check("key0_code", int'(key_code_o), 0);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check("arst_col", int'(col_sel_o), 0);
      check("arst_code", int'(key_code_o), 0);
      check("arst_valid", int'(key_valid_o), 0);
      check("arst_held", int'(key_held_o), 0);
      repeat (2) @(negedge clk);
      v0 = n_valid;
      rst_n = 1'b1;
      wait_held(1'b1, 100);
      check("redetect_code", int'(key_code_o), 0);
      repeat (8) @(negedge clk);
      check("redetect_pulses", n_valid - v0, 1);
      keys_down = 16'h0000;
      wait_held(1'b0, 100);

      // randomized presses, bounces, multi-key and chatter
      for (int it = 0; it < 60; it++) begin
         int k;
         int dur;
         int kind;
         k    = $urandom_range(0, 15);
         kind = $urandom_range(0, 3);
         dur  = $urandom_range(30, 90);
         case (kind)
            0: keys_down = 16'(1 << k);
            1: begin keys_down = 16'(1 << k); dur = $urandom_range(1, 6); end
            2: keys_down = 16'(1 << k) | 16'(1 << $urandom_range(0, 15));
            default: keys_down = 16'(1 << k);
         endcase
         for (int c = 0; c < dur; c++) begin
            @(negedge clk);
            if (kind == 3 && $urandom_range(0, 7) == 0) keys_down[k] = ~keys_down[k];
         end
         keys_down = 16'h0000;
         repeat ($urandom_range(5, 40)) @(negedge clk);
      end

      repeat (100) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
